// File: rtl/ntt_pkg.sv
// ntt_pkg: shared definitions for the NTT read-address generator.
//   - state_e         : controller FSM states
//   - MAX_LOG_N       : widest supported log2(N), sizes the parity helper
//   - calc_n/calc_aw  : derive N and the per-bank address width from LOG_N
//   - parity          : XOR-reduction used to pick the memory bank of an index
package ntt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int MAX_LOG_N = 16;

  function automatic int calc_n(input int log_n);
    return 1 << log_n;
  endfunction

  // Each of the two banks holds N/2 words.
  function automatic int calc_aw(input int log_n);
    return log_n - 1;
  endfunction

  function automatic logic parity(input logic [MAX_LOG_N-1:0] x);
    return ^x;
  endfunction

endpackage

// File: rtl/ntt_bank_map.sv
// ntt_bank_map: combinational mapping of a butterfly's operand indices onto
// the two coefficient banks.
//   i_j, i_k : butterfly operand indices (LOG_N bits)
//   o_addr0  : address of whichever operand lives in bank 0
//   o_addr1  : address of the other operand (bank 1)
//   o_swap   : 1 when the upper operand (j) lives in bank 1
module ntt_bank_map
  import ntt_pkg::*;
#(
  parameter int LOG_N = 12
) (
  input  logic [LOG_N-1:0] i_j,
  input  logic [LOG_N-1:0] i_k,
  output logic [LOG_N-2:0] o_addr0,
  output logic [LOG_N-2:0] o_addr1,
  output logic             o_swap
);

  localparam int AW = calc_aw(LOG_N);

  // j and k differ in exactly one bit, so they always land in opposite banks.
  always_comb begin
    o_swap  = parity(MAX_LOG_N'(i_j));
    o_addr0 = AW'(i_j >> 1);
    o_addr1 = AW'(i_k >> 1);
    if (o_swap) begin
      o_addr0 = AW'(i_k >> 1);
      o_addr1 = AW'(i_j >> 1);
    end
  end

endmodule

// File: rtl/ntt_rd_addr_gen.sv
// ntt_rd_addr_gen: read-address sequencer for an in-place NTT/INTT over a
// two-bank coefficient memory.
//   clk, rst_n         : clock, asynchronous active-low reset
//   i_start, i_intt    : start request and transform select (latched at start)
//   i_ready            : downstream accepts the current butterfly
//   o_valid            : butterfly outputs are valid (RUN only)
//   o_rd_addr0/1       : bank 0 / bank 1 read addresses
//   o_alu_inout_swap   : upper operand resides in bank 1
//   o_tw_addr          : twiddle ROM address
//   o_busy, o_done     : transform in progress / one-cycle completion pulse
module ntt_rd_addr_gen
  import ntt_pkg::*;
#(
  parameter int LOG_N        = 12,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_intt,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [LOG_N-2:0] o_rd_addr0,
  output logic [LOG_N-2:0] o_rd_addr1,
  output logic             o_alu_inout_swap,
  output logic [LOG_N-1:0] o_tw_addr,
  output logic             o_busy,
  output logic             o_done
);

  localparam int AW     = calc_aw(LOG_N);
  localparam int N      = calc_n(LOG_N);
  localparam int HALF_N = N / 2;
  localparam int SW     = $clog2(LOG_N + 1);
  localparam int DW     = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   b_q, b_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            intt_q, intt_d;

  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            swap_q, swap_d;
  logic [AW-1:0]   addr0_q, addr0_d;
  logic [AW-1:0]   addr1_q, addr1_d;
  logic [LOG_N-1:0] tw_q, tw_d;

  logic [SW-1:0]    s;
  logic [LOG_N-1:0] b_ext, half_v, j, k;
  logic [AW-1:0]    map_addr0, map_addr1;
  logic             map_swap;
  logic             accept;

  assign accept = valid_q & i_ready;

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    stage_d = stage_q;
    drain_d = drain_q;
    intt_d  = intt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_RUN;
          intt_d  = i_intt;
          b_d     = '0;
          stage_d = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (b_q == AW'(HALF_N - 1)) begin
            b_d     = '0;
            drain_d = '0;
            state_d = ST_DRAIN;
          end else begin
            b_d = b_q + AW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
          drain_d = '0;
          if (stage_q == SW'(LOG_N - 1)) begin
            stage_d = '0;
            state_d = ST_DONE;
          end else begin
            stage_d = stage_q + SW'(1);
            state_d = ST_RUN;
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered outputs line
  // up with the state they describe; a stall leaves b_d unchanged, so they hold.
  always_comb begin
    s      = intt_d ? stage_d : (SW'(LOG_N - 1) - stage_d);
    b_ext  = {1'b0, b_d};
    half_v = LOG_N'(1) << s;
    j      = ((b_ext >> s) << (s + SW'(1))) | (b_ext & (half_v - LOG_N'(1)));
    k      = j | half_v;
  end

  ntt_bank_map #(
    .LOG_N (LOG_N)
  ) u_bank_map (
    .i_j     (j),
    .i_k     (k),
    .o_addr0 (map_addr0),
    .o_addr1 (map_addr1),
    .o_swap  (map_swap)
  );

  always_comb begin
    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    swap_d  = 1'b0;
    addr0_d = '0;
    addr1_d = '0;
    tw_d    = '0;
    if (valid_d) begin
      swap_d  = map_swap;
      addr0_d = map_addr0;
      addr1_d = map_addr1;
      // N/(2*half) selects the stage's twiddle block, j>>(s+1) the group.
      tw_d    = (LOG_N'(HALF_N) >> s) + (j >> (s + SW'(1)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
      stage_q <= '0;
      drain_q <= '0;
      intt_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      swap_q  <= 1'b0;
      addr0_q <= '0;
      addr1_q <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      stage_q <= stage_d;
      drain_q <= drain_d;
      intt_q  <= intt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      swap_q  <= swap_d;
      addr0_q <= addr0_d;
      addr1_q <= addr1_d;
      tw_q    <= tw_d;
    end
  end

  assign o_valid          = valid_q;
  assign o_busy           = busy_q;
  assign o_done           = done_q;
  assign o_alu_inout_swap = swap_q;
  assign o_rd_addr0       = addr0_q;
  assign o_rd_addr1       = addr1_q;
  assign o_tw_addr        = tw_q;

endmodule

// File: tb/tb_ntt_rd_addr_gen.sv
// tb_ntt_rd_addr_gen: self-checking bench for ntt_rd_addr_gen at LOG_N=3,
// DRAIN_CYCLES=2. Expected beat sequences come from a loop-over-groups model.
module tb_ntt_rd_addr_gen;

  localparam int LOG_N        = 3;
  localparam int DRAIN_CYCLES = 2;
  localparam int N            = 1 << LOG_N;
  localparam int AW           = LOG_N - 1;
  localparam int TOTAL        = LOG_N * N / 2;

  typedef struct packed {
    logic [AW-1:0]    a0;
    logic [AW-1:0]    a1;
    logic             swap;
    logic [LOG_N-1:0] tw;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_start;
  logic             i_intt;
  logic             i_ready;
  logic             o_valid;
  logic [AW-1:0]    o_rd_addr0;
  logic [AW-1:0]    o_rd_addr1;
  logic             o_alu_inout_swap;
  logic [LOG_N-1:0] o_tw_addr;
  logic             o_busy;
  logic             o_done;

  int checks = 0;
  int errors = 0;

  beat_t exp_q[$];
  beat_t acc_q[$];

  ntt_rd_addr_gen #(
    .LOG_N        (LOG_N),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_start          (i_start),
    .i_intt           (i_intt),
    .i_ready          (i_ready),
    .o_valid          (o_valid),
    .o_rd_addr0       (o_rd_addr0),
    .o_rd_addr1       (o_rd_addr1),
    .o_alu_inout_swap (o_alu_inout_swap),
    .o_tw_addr        (o_tw_addr),
    .o_busy           (o_busy),
    .o_done           (o_done)
  );

  always #5 clk = ~clk;

  // Enumerate butterflies stage by stage, group by group.
  function automatic void build_expected(input bit intt);
    int half;
    int j;
    int k;
    beat_t bt;
    exp_q.delete();
    for (int st = 0; st < LOG_N; st++) begin
      half = intt ? (1 << st) : (N >> (st + 1));
      for (int g = 0; g < N; g += 2 * half) begin
        for (int i = 0; i < half; i++) begin
          j = g + i;
          k = j + half;
          bt.swap = ($countones(j) % 2) == 1;
          if (bt.swap) begin
            bt.a0 = AW'(k / 2);
            bt.a1 = AW'(j / 2);
          end else begin
            bt.a0 = AW'(j / 2);
            bt.a1 = AW'(k / 2);
          end
          bt.tw = LOG_N'(N / (2 * half) + g / (2 * half));
          exp_q.push_back(bt);
        end
      end
    end
  endfunction

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({o_valid, o_busy, o_done, o_alu_inout_swap, o_rd_addr0, o_rd_addr1, o_tw_addr} !== '0) begin
      errors++;
      $display("[TB] FAIL %s: got v=%b b=%b d=%b sw=%b a0=%0d a1=%0d tw=%0d required all 0",
               name, o_valid, o_busy, o_done, o_alu_inout_swap, o_rd_addr0, o_rd_addr1, o_tw_addr);
    end
  endtask

  // Runs one full transform, checking every accepted beat, stall stability,
  // drain gaps and the done pulse. Accepted beats are left in acc_q.
  task automatic run_transform(input string name, input bit intt, input bit rand_ready,
                               input bit inject_start);
    int    idx = 0;
    int    dones = 0;
    int    idle = 0;
    bit    seen_valid = 0;
    bit    prev_stall = 0;
    bit    finished = 0;
    beat_t cur;
    beat_t prev = '0;
    build_expected(intt);
    acc_q.delete();
    i_intt  = intt;
    i_start = 1'b1;
    i_ready = 1'b1;
    wait_cycle();
    i_start = 1'b0;
    i_intt  = 1'($urandom % 2);
    for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
      cur = {o_rd_addr0, o_rd_addr1, o_alu_inout_swap, o_tw_addr};
      if (prev_stall) begin
        checks++;
        if (o_valid !== 1'b1 || cur !== prev) begin
          errors++;
          $display("[TB] FAIL %s stall_hold: got v=%b %h required v=1 %h", name, o_valid, cur, prev);
        end
      end
      if (o_valid) begin
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
          errors++;
          $display("[TB] FAIL %s busy_in_run: got busy=%b done=%b required 1/0", name, o_busy, o_done);
        end
        if (seen_valid && idle != 0) begin
          checks++;
          if (idle != DRAIN_CYCLES) begin
            errors++;
            $display("[TB] FAIL %s stage_gap: got %0d required %0d", name, idle, DRAIN_CYCLES);
          end
        end
        idle = 0;
        seen_valid = 1;
      end else if (o_done) begin
        dones++;
        finished = 1;
        checks++;
        if (idle != DRAIN_CYCLES || o_busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL %s final_drain: got idle=%0d busy=%b required %0d/1", name, idle, o_busy, DRAIN_CYCLES);
        end
        checks++;
        if (idx != TOTAL) begin
          errors++;
          $display("[TB] FAIL %s accept_count: got %0d required %0d", name, idx, TOTAL);
        end
      end else if (o_busy) begin
        idle++;
      end else begin
        errors++;
        checks++;
        $display("[TB] FAIL %s went_idle: got busy=0 done=0 after %0d beats required done pulse", name, idx);
        finished = 1;
      end
      i_start = inject_start && idx == 3;
      i_intt  = ~intt;
      i_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
      if (o_valid && i_ready) begin
        checks++;
        if (idx >= exp_q.size()) begin
          errors++;
          $display("[TB] FAIL %s extra_beat: got beat %0d=%h required none", name, idx, cur);
        end else if (cur !== exp_q[idx]) begin
          errors++;
          $display("[TB] FAIL %s beat %0d: got %h required %h", name, idx, cur, exp_q[idx]);
        end
        acc_q.push_back(cur);
        idx++;
      end
      prev_stall = o_valid && !i_ready;
      prev = cur;
      wait_cycle();
    end
    i_start = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s timeout: got no done after 2000 cycles required done", name);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL %s after_done: got done=%b busy=%b valid=%b required 0", name, o_done, o_busy, o_valid);
      end
      wait_cycle();
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("[TB] FAIL %s done_count: got %0d required 1", name, dones);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_intt  = 1'b0;
    i_ready = 1'b0;
    #2;
    check_all_zero("reset_async");
    wait_cycle();
    wait_cycle();
    check_all_zero("reset_held");
    rst_n = 1'b1;
    wait_cycle();
    check_all_zero("reset_release_idle");
  endtask

  task automatic test_ntt_basic();
    beat_t want;
    run_transform("ntt_ready", 1'b0, 1'b0, 1'b0);
    if (acc_q.size() == TOTAL) begin
      want = {2'd0, 2'd2, 1'b0, 3'd1};
      checks++;
      if (acc_q[0] !== want) begin
        errors++;
        $display("[TB] FAIL ntt_first_beat: got %h required %h", acc_q[0], want);
      end
      want = {2'd2, 2'd0, 1'b1, 3'd1};
      checks++;
      if (acc_q[1] !== want) begin
        errors++;
        $display("[TB] FAIL ntt_second_beat: got %h required %h", acc_q[1], want);
      end
      want = {2'd3, 2'd3, 1'b0, 3'd7};
      checks++;
      if (acc_q[TOTAL-1] !== want) begin
        errors++;
        $display("[TB] FAIL ntt_last_beat: got %h required %h", acc_q[TOTAL-1], want);
      end
    end
  endtask

  task automatic test_intt_basic();
    beat_t want;
    run_transform("intt_ready", 1'b1, 1'b0, 1'b0);
    if (acc_q.size() == TOTAL) begin
      want = {2'd0, 2'd0, 1'b0, 3'd4};
      checks++;
      if (acc_q[0] !== want) begin
        errors++;
        $display("[TB] FAIL intt_first_beat: got %h required %h", acc_q[0], want);
      end
    end
  endtask

  task automatic test_random_ready();
    run_transform("ntt_rand_ready", 1'b0, 1'b1, 1'b0);
    run_transform("intt_rand_ready", 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_transform("ntt_start_in_run", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_mid_reset();
    i_intt  = 1'b0;
    i_start = 1'b1;
    i_ready = 1'b1;
    wait_cycle();
    i_start = 1'b0;
    for (int c = 0; c < 5; c++) wait_cycle();
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset_immediate");
    for (int c = 0; c < 3; c++) begin
      wait_cycle();
      check_all_zero("mid_reset_held");
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      wait_cycle();
      check_all_zero("mid_reset_released");
    end
    run_transform("ntt_after_reset", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_transform("b2b_intt", 1'b1, 1'b1, 1'b0);
    run_transform("b2b_ntt", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ntt_basic();
    test_intt_basic();
    test_random_ready();
    test_start_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
